// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding used by the ALU, its issuer and the bench.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } op_type;

  localparam int STAT_W = 16;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Request, response and ALU-side signals of alu_op_issuer.
// master = command source / ALU side, slave = the issuer.
interface alu_op_issuer_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic               req_valid;
  logic               req_ready;
  op_type             req_mode;
  logic [WIDTH-1:0]   req_value1;
  logic [WIDTH-1:0]   req_value2;
  logic [TAG_W-1:0]   req_tag;

  op_type             alu_mode;
  logic [WIDTH-1:0]   alu_value1;
  logic [WIDTH-1:0]   alu_value2;
  logic [2*WIDTH-1:0] alu_result;
  logic               alu_correct;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_result;
  logic               rsp_correct;
  logic [TAG_W-1:0]   rsp_tag;

  modport master (
    output req_valid, req_mode, req_value1, req_value2, req_tag,
    output rsp_ready, alu_result, alu_correct,
    input  req_ready, alu_mode, alu_value1, alu_value2,
    input  rsp_valid, rsp_result, rsp_correct, rsp_tag
  );

  modport slave (
    input  req_valid, req_mode, req_value1, req_value2, req_tag,
    input  rsp_ready, alu_result, alu_correct,
    output req_ready, alu_mode, alu_value1, alu_value2,
    output rsp_valid, rsp_result, rsp_correct, rsp_tag
  );

endinterface

// File: rtl/alu_rsp_fifo.sv
// Show-ahead response FIFO; head reads as zero while empty so outputs are clean after reset.
module alu_rsp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  // Overflow and underflow requests are dropped rather than corrupting state.
  assign do_push = push && (count_reg != FULL_CNT);
  assign do_pop  = pop && (count_reg != '0);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/alu_op_issuer.sv
// Serialises requests onto the ALU one at a time and queues tagged results.
// Optional ALU_ISSUER_STATS_EN adds saturating op/error counters.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  alu_op_issuer_if.slave     bus
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_ops,
  output logic [STAT_W-1:0]  stat_errs
`endif
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = TAG_W + 2 * WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  op_type            mode_reg;
  logic [WIDTH-1:0]  value1_reg;
  logic [WIDTH-1:0]  value2_reg;
  logic [TAG_W-1:0]  tag_reg;

  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] head_data;

  // Only one op is ever in flight and only from IDLE, so FIFO space alone gates acceptance.
  assign bus.req_ready = !reset && (state_reg == IDLE) && (fifo_count != FULL_CNT);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      mode_reg   <= ADD;
      value1_reg <= '0;
      value2_reg <= '0;
      tag_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mode_reg   <= bus.req_mode;
        value1_reg <= bus.req_value1;
        value2_reg <= bus.req_value2;
        tag_reg    <= bus.req_tag;
      end
    end
  end

  // Operand registers double as the ALU drive, so they hold steady between ops.
  assign bus.alu_mode   = mode_reg;
  assign bus.alu_value1 = value1_reg;
  assign bus.alu_value2 = value2_reg;

  assign push_data = {tag_reg, bus.alu_result, bus.alu_correct};
  assign pop       = bus.rsp_ready;

  alu_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.rsp_valid   = !fifo_empty;
  assign bus.rsp_tag     = head_data[DATA_W-1 -: TAG_W];
  assign bus.rsp_result  = head_data[2*WIDTH:1];
  assign bus.rsp_correct = head_data[0];

`ifdef ALU_ISSUER_STATS_EN
  logic [STAT_W-1:0] stat_ops_reg;
  logic [STAT_W-1:0] stat_errs_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_ops_reg  <= '0;
      stat_errs_reg <= '0;
    end else if (push) begin
      if (stat_ops_reg != '1) stat_ops_reg <= stat_ops_reg + STAT_W'(1);
      if (!bus.alu_correct && (stat_errs_reg != '1)) stat_errs_reg <= stat_errs_reg + STAT_W'(1);
    end
  end

  assign stat_ops  = stat_ops_reg;
  assign stat_errs = stat_errs_reg;
`endif

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Initiator-side driver for the team's ALU: accepts operation requests over a valid/ready port, drives them onto the ALU operand/mode interface, captures the ALU's registered `result` and `correct` outputs, and returns tagged responses through a small response FIFO. It sits between a command source (bench sequencer or control logic) and the ALU, serialising one operation at a time.

## Interface
Parameters:
- `WIDTH`, default 8: operand width.
- `TAG_W`, default 4: request tag width, passed through unchanged.
- `DEPTH`, default 4: response FIFO entries, power of two, ≥2.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on an edge where valid&ready.
- `req_mode`  in  2  op_type: ADD=0, SUB=1, MUL=2, DIV=3.
- `req_value1`, `req_value2`  in  WIDTH  operands.
- `req_tag`  in  TAG_W  request identifier.
- `alu_mode`  out  2  to ALU.
- `alu_value1`, `alu_value2`  out  WIDTH  to ALU.
- `alu_result`  in  2*WIDTH  from ALU, registered on ALU clock edge.
- `alu_correct`  in  1  from ALU, 0 = invalid op (SUB underflow, DIV by zero).
- `rsp_valid`  out  1  FIFO non-empty.
- `rsp_ready`  in  1  consumer pops on valid&ready.
- `rsp_result`  out  2*WIDTH, `rsp_correct`  out  1, `rsp_tag`  out  TAG_W  head entry (show-ahead).

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: `req_ready` = 1 iff FIFO count + in-flight < DEPTH (only one op ever in flight). On valid&ready: register mode/value1/value2 onto `alu_*` outputs, latch tag, go ISSUE.
- ISSUE: `alu_*` held stable; ALU samples them on this edge. Go CAPTURE.
- CAPTURE: write {tag, `alu_result`, `alu_correct`} into FIFO; go IDLE.
- `alu_*` outputs hold last issued values in IDLE (no toggling between ops).
- Result/correct are passed through unmodified; issuer performs no arithmetic.
- FIFO: read/write pointers `$clog2(DEPTH)` bits, wrap modulo DEPTH; count `$clog2(DEPTH)+1` bits. Simultaneous push and pop: count unchanged, both pointers advance. Pop when empty ignored. Push cannot occur when full (guaranteed by `req_ready` gating).
- Reset (any time, including mid-operation): FSM→IDLE, in-flight op dropped, FIFO emptied, pointers/count 0.

## Timing
- Reset values: `req_ready`=0 while reset asserted, 1 the cycle after release (FIFO empty); `alu_mode`=ADD, `alu_value1`=`alu_value2`=0; `rsp_valid`=0; `rsp_result`=0, `rsp_correct`=0, `rsp_tag`=0.
- Accept at edge E → `alu_*` valid after E → ALU registers at E+1 → FIFO write at E+2 → `rsp_valid` high after E+2 (if FIFO was empty).
- Throughput: one request per 3 cycles; `req_ready` low in ISSUE and CAPTURE.
- `rsp_*` change only on a pop or on a push into an empty FIFO.

## Configuration
- `ALU_ISSUER_STATS_EN` defined: adds outputs `stat_ops` (16 b, count of captured ops) and `stat_errs` (16 b, count of captures with `alu_correct`=0), both saturating at 16'hFFFF, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package `alu_pkg`: `op_type` enum (ADD, SUB, MUL, DIV, 2-bit, fixed encoding), shared with the ALU and bench; FSM state typedef local to the module.
- One sub-module: `alu_rsp_fifo` (parameterised width/depth, show-ahead, count output).

## Test plan
- ADD 5+3, tag 1 → `rsp_valid` two edges after accept, result 16'd8, correct 1, tag 1.
- SUB 3−5, tag 2 → result 16'hFFFE, correct 0; with STATS_EN `stat_errs`=1.
- DIV 7/0 then MUL 255×255 back-to-back → responses in order: (0, correct 0), (16'hFE01, correct 1).
- `rsp_ready`=0, issue 4 ADDs (DEPTH=4) → `req_ready` stays 0 after 4th capture; one pop → `req_ready` returns 1 next cycle; drain gives tags in issue order across pointer wrap.
- Simultaneous pop and capture with count=2 → count stays 2, correct head order.
- Assert `reset` during ISSUE of DIV 9/3 → no response ever appears, `rsp_valid`=0, `alu_*`=0/ADD, next request completes normally.
